// File: rtl/pb_tap_pkg.sv
// Opcodes, decode types and decode helpers for the parametrised TAP instruction register.
// Pure declarations: no state, no latency.
package pb_tap_pkg;

  localparam logic [3:0] IDCODE       = 4'b0001;
  localparam logic [3:0] SCAN_TEST    = 4'b0010;
  localparam logic [3:0] LOAD_PROGRAM = 4'b1000;
  localparam logic [3:0] BYPASS4      = 4'b1111;

  localparam int MAX_IR_WIDTH = 32;

  typedef logic [MAX_IR_WIDTH-1:0] ir_word_t;

  typedef enum logic [3:0] {
    TAP_IDCODE       = IDCODE,
    TAP_SCAN_TEST    = SCAN_TEST,
    TAP_LOAD_PROGRAM = LOAD_PROGRAM,
    TAP_BYPASS       = BYPASS4
  } tap_instr_e;

  typedef struct packed {
    logic bypass;
    logic idcode;
    logic scan;
    logic load;
  } tap_sel_t;

  // BYPASS is all ones at the configured IR width, not just the low nibble.
  function automatic tap_sel_t decode_opcode(input ir_word_t op, input int w);
    ir_word_t ones;
    tap_sel_t sel;
    ones       = (w >= MAX_IR_WIDTH) ? '1 : ((ir_word_t'(1) << w) - ir_word_t'(1));
    sel.bypass = (op == ones);
    sel.idcode = (op == ir_word_t'(IDCODE));
    sel.scan   = (op == ir_word_t'(SCAN_TEST));
    sel.load   = (op == ir_word_t'(LOAD_PROGRAM));
    return sel;
  endfunction

  function automatic logic is_legal_opcode(input ir_word_t op, input int w);
    return |decode_opcode(op, w);
  endfunction

endpackage

// File: rtl/pb_tap_ir_gen_if.sv
// TAP controller <-> instruction register signal bundle.
// master = TAP controller side (drives strobes/tdi/status), slave = instruction register.
interface pb_tap_ir_gen_if #(
  parameter int IR_WIDTH     = 4,
  parameter int STATUS_WIDTH = 2
);

  logic                    tlr_i;
  logic                    captureIR_i;
  logic                    shiftIR_i;
  logic                    updateIR_i;
  logic                    tdi_i;
  logic [STATUS_WIDTH-1:0] status_i;
  logic                    tdo_o;
  logic [IR_WIDTH-1:0]     instruction_o;
  logic                    illegal_o;
  logic                    sel_bypass_o;
  logic                    sel_idcode_o;
  logic                    sel_scan_o;
  logic                    sel_load_o;

  modport master (
    output tlr_i, captureIR_i, shiftIR_i, updateIR_i, tdi_i, status_i,
    input  tdo_o, instruction_o, illegal_o,
    input  sel_bypass_o, sel_idcode_o, sel_scan_o, sel_load_o
  );

  modport slave (
    input  tlr_i, captureIR_i, shiftIR_i, updateIR_i, tdi_i, status_i,
    output tdo_o, instruction_o, illegal_o,
    output sel_bypass_o, sel_idcode_o, sel_scan_o, sel_load_o
  );

endinterface

// File: rtl/pb_tap_ir_decode.sv
// Combinational opcode -> one-hot select and legality flag; zero latency, no flow control.
module pb_tap_ir_decode
  import pb_tap_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic [IR_WIDTH-1:0] i_opcode,
  output tap_sel_t            o_sel,
  output logic                o_legal
);

  always_comb begin
    o_sel = decode_opcode(ir_word_t'(i_opcode), IR_WIDTH);
  end

  assign o_legal = is_legal_opcode(ir_word_t'(i_opcode), IR_WIDTH);

endmodule

// File: rtl/pb_tap_ir_gen.sv
// JTAG instruction register: capture/shift chain plus update shadow with one-hot decode.
// Update is visible the cycle after the strobe edge; the TAP strobes are never stalled.
module pb_tap_ir_gen
  import pb_tap_pkg::*;
#(
  parameter int                IR_WIDTH     = 4,
  parameter int                STATUS_WIDTH = 2,
  parameter logic [IR_WIDTH-1:0] RESET_INSTR  = IR_WIDTH'(IDCODE)
) (
  input logic           tck_i,
  input logic           trst,
  pb_tap_ir_gen_if.slave ir
);

  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = '1;
  localparam tap_sel_t RESET_SEL  = decode_opcode(ir_word_t'(RESET_INSTR), IR_WIDTH);
  localparam tap_sel_t BYPASS_SEL = tap_sel_t'(4'b1000);

  logic [IR_WIDTH-1:0] r_shift;
  logic [IR_WIDTH-1:0] r_instr;
  logic                r_illegal;
  tap_sel_t            r_sel;

  logic [IR_WIDTH-1:0] w_capture;
  tap_sel_t            w_sel;
  logic                w_legal;

  assign w_capture = IR_WIDTH'({ir.status_i, 2'b01});

  // Decode the shift chain so the select vector can be registered alongside the shadow.
  pb_tap_ir_decode #(
    .IR_WIDTH (IR_WIDTH)
  ) u_decode (
    .i_opcode (r_shift),
    .o_sel    (w_sel),
    .o_legal  (w_legal)
  );

  always_ff @(posedge tck_i) begin
    if (trst) begin
      r_shift   <= RESET_INSTR;
      r_instr   <= RESET_INSTR;
      r_illegal <= 1'b0;
      r_sel     <= RESET_SEL;
    end else if (ir.tlr_i) begin
      r_instr   <= RESET_INSTR;
      r_illegal <= 1'b0;
      r_sel     <= RESET_SEL;
    end else if (ir.updateIR_i) begin
      if (w_legal) begin
        r_instr   <= r_shift;
        r_illegal <= 1'b0;
        r_sel     <= w_sel;
      end else begin
        r_instr   <= BYPASS_INSTR;
        r_illegal <= 1'b1;
        r_sel     <= BYPASS_SEL;
      end
    end else if (ir.captureIR_i) begin
      r_shift <= w_capture;
    end else if (ir.shiftIR_i) begin
      r_shift <= {ir.tdi_i, r_shift[IR_WIDTH-1:1]};
    end
  end

  assign ir.tdo_o         = r_shift[0];
  assign ir.instruction_o = r_instr;
  assign ir.illegal_o     = r_illegal;
  assign ir.sel_bypass_o  = r_sel.bypass;
  assign ir.sel_idcode_o  = r_sel.idcode;
  assign ir.sel_scan_o    = r_sel.scan;
  assign ir.sel_load_o    = r_sel.load;

endmodule

// File: doc/pb_tap_ir_gen.md
Name: pb_tap_ir_gen

Overview:
Parametrised JTAG TAP instruction register. It is the successor to the fixed 4-bit IR.
- Adds generic IR width and an IEEE 1149.1 Capture-IR load (status bits plus the mandatory "01" LSBs).
- Adds Test-Logic-Reset handling, illegal-opcode fallback to BYPASS, and one-hot instruction decode.
- Sits between the TAP controller FSM (supplies capture/shift/update/tlr strobes) and the data-register mux / program loader.

Parameters:
- IR_WIDTH, 4: instruction length in bits. Must be >= STATUS_WIDTH+2 and >= 4.
- STATUS_WIDTH, 2: number of status bits captured into IR[STATUS_WIDTH+1:2] during Capture-IR.
- RESET_INSTR, pb_tap_pkg::IDCODE (zero-extended): instruction value after reset or Test-Logic-Reset.

Ports:
- tck_i  in  1  TAP clock; all state updates on rising edge.
- trst  in  1  reset. Synchronous and active-high.
- tlr_i  in  1  TAP controller is in Test-Logic-Reset.
- captureIR_i  in  1  Capture-IR strobe.
- shiftIR_i  in  1  Shift-IR enable.
- updateIR_i  in  1  Update-IR strobe.
- tdi_i  in  1  serial data in.
- status_i  in  STATUS_WIDTH  status word loaded on capture.
- tdo_o  out  1  serial data out, equal to shift_reg[0] (combinational from flop).
- instruction_o  out  IR_WIDTH  active (shadow) instruction.
- illegal_o  out  1  last update carried an undefined opcode.
- sel_bypass_o / sel_idcode_o / sel_scan_o / sel_load_o  out  1 each  one-hot decode of instruction_o.

Behaviour:
- State: shift_reg[IR_WIDTH-1:0], shadow instr[IR_WIDTH-1:0], illegal flag.
- Per-edge priority: trst > tlr_i > updateIR_i > captureIR_i > shiftIR_i. Only the highest active term acts on each register.
- trst=1 at the edge:
  - instr <= RESET_INSTR; shift_reg <= RESET_INSTR; illegal <= 0.
  - Outputs reset values: instruction_o=RESET_INSTR, sel_idcode_o=1, other sel_*=0, illegal_o=0, tdo_o=RESET_INSTR[0].
- tlr_i=1 (no trst): same as trst for instr and illegal; shift_reg holds.
- captureIR_i: shift_reg <= {zeros, status_i, 2'b01}. Upper bits above STATUS_WIDTH+2 are 0.
- shiftIR_i: shift_reg <= {tdi_i, shift_reg[IR_WIDTH-1:1]}.
  - LSB shifted out first; tdi enters the MSB.
  - After exactly IR_WIDTH shifts, shift_reg holds the word presented LSB-first.
- updateIR_i with a legal opcode (IDCODE, SCAN_TEST, LOAD_PROGRAM, BYPASS): instr <= shift_reg; illegal <= 0.
- updateIR_i with an undefined opcode: instr <= BYPASS (all ones); illegal <= 1. illegal stays set until the next legal update, tlr or trst.
- Update latency: instruction_o and sel_* change on the same edge that samples updateIR_i=1. They are visible in the following cycle; there is no extra pipeline stage.
- shift_reg is unaffected by update. Shift and update in the same cycle: update wins and shift_reg holds.
- Shift held longer than IR_WIDTH cycles: bits keep wrapping out of tdo_o. This is the normal 1149.1 behaviour; no error is raised.
- Capture and shift in the same cycle: capture wins.
- instr never changes during shift or capture. It changes only on update, tlr or trst.
- Decode: exactly one sel_* is high at all times, since instr is always a legal opcode.

Decomposition:
- Package pb_tap_pkg holds:
  - opcode constants IDCODE=4'b0001, SCAN_TEST=4'b0010, LOAD_PROGRAM=4'b1000 (zero-extended to IR_WIDTH);
  - BYPASS = all ones;
  - enum tap_instr_e;
  - function is_legal_opcode().
- One sub-module, pb_tap_ir_decode: combinational opcode -> one-hot sel vector and legality flag. Shift, shadow and priority logic stay in the top.

Test Plan:
1. trst pulse for 1 cycle -> instruction_o=4'b0001, sel_idcode_o=1, illegal_o=0, tdo_o=1.
2. captureIR with status_i=2'b10, then 4 shifts with tdi=0 -> tdo_o sequence 1,0,0,1 (LSB first), shift_reg then 4'b0000.
3. Shift LOAD_PROGRAM 4'b1000 LSB-first (4 cycles), then update -> instruction_o=4'b1000, sel_load_o=1. Repeat with SCAN_TEST 4'b0010 -> sel_scan_o=1.
4. Shift 4'b0101 then update -> instruction_o=4'b1111, sel_bypass_o=1, illegal_o=1. Then load 4'b0010 -> illegal_o=0.
5. Shift partial 2 bits of 4'b1000 and assert tlr_i -> instruction_o=4'b0001; finish shifting then update -> 4'b1000.
6. updateIR_i and shiftIR_i together with tdi=1 -> shift_reg unchanged, instr updated. trst asserted mid-shift -> all reset values on the next cycle.
